mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RISC-V core. It sits between execute and the register file write port. It accepts one instruction at a time from execute and performs loads and stores as byte-serial transfers over an 8-bit memory port. It then drives the register file write address and data (port3_in / data_in). ALU results pass through with one-cycle latency; execute is stalled while a memory transfer is in progress.

## Interface
Parameters:
- none (address 32 b, data 32 b, memory byte lane 8 b fixed)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept; high only in IDLE
- ex_is_load / ex_is_store  in  1 each  memory op kind; both low = ALU pass-through; both high never driven
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data, bytes sent little-endian
- ex_rd  in  5  destination register
- ex_result  in  32  ALU result for pass-through
- mem_req  out  1  byte request valid
- mem_we  out  1  1 = write byte, 0 = read byte
- mem_addr  out  32  byte address
- mem_wdata  out  8  write byte
- mem_grant  in  1  memory accepts the current request this cycle
- mem_rdata  in  8  read byte, valid the cycle after its read was granted
- wb_valid  out  1  retirement strobe
- wb_rd  out  5  register file write address; 0 when nothing retires
- wb_data  out  32  register file write data; 0 when nothing retires

## Operation
- Reset: state IDLE, counters 0; mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_rd 0, wb_data 0, ex_ready 1 once reset deasserts.
- Access size: funct3[1:0] = 00 gives 1 byte, 01 gives 2 bytes, otherwise 4 bytes. Loads sign-extend when funct3[2] = 0.
- States:
  - IDLE: on ex_valid & ex_ready:
    - ALU op: register rd and ex_result to the wb outputs; stay in IDLE.
    - Load or store: latch addr, wdata, rd, funct3, and kind; go to XFER.
  - XFER: mem_req = 1, mem_addr = base + k (mod 2^32), mem_wdata = byte k of wdata. k advances on mem_grant. After the grant of the last byte:
    - Store: go to RETIRE.
    - Load: go to DRAIN.
  - DRAIN (load only): capture the final mem_rdata byte; go to RETIRE.
  - RETIRE:
    - Load: wb_rd = rd, wb_data = assembled and extended word, wb_valid = 1.
    - Store: wb_valid = 1, wb_rd = 0.
    - Then go to IDLE.
- Load data capture: read bytes are captured in the cycle after each grant, into lane j of an assembly register, where j is the receive counter. Captures overlap with later requests.
- rd = 0 on a load: the bus transfer still completes; wb_rd = 0 at retire.
- No alignment check: misaligned and wrapping addresses (0xFFFF_FFFF + 1 → 0x0000_0000) are legal.
- Asynchronous reset mid-transfer: the cycle is abandoned. mem_req drops immediately, and a late mem_rdata is ignored.

## Timing
- Zero-wait memory (grant every cycle), with the instruction accepted at edge T:
  - ALU op: wb at T+1.
  - SB: retire at T+2.
  - SW: retire at T+5.
  - LB: retire at T+3.
  - LW: retire at T+6.
- Each cycle with mem_grant low adds one cycle.
- ex_ready is low from the edge after acceptance until RETIRE has completed. A new instruction can be accepted in the cycle after RETIRE.
- wb_valid, wb_rd, and wb_data are registered, each asserted for exactly one cycle per retirement. In all other cycles they are 0.
- mem_req, mem_addr, mem_we, and mem_wdata are registered and stable while mem_grant is low.

## Structure
- Shared package riscv_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding mem_state_t (IDLE, XFER, DRAIN, RETIRE);
  - width constants XLEN = 32, REG_AW = 5.
- Sub-module load_extend: combinational. Takes the assembly register and funct3; returns the 32-bit sign- or zero-extended value.

## Test plan
- ALU pass-through: rd = 5, result 0x1234_5678 → wb_valid, wb_rd = 5, wb_data = 0x1234_5678 one cycle later; mem_req never asserts.
- LB at 0x100 with memory byte 0x80 → wb_data = 0xFFFF_FF80. LBU at the same address → 0x0000_0080. Each retires 3 cycles after accept.
- LW at 0x0000_0201 with bytes 0x11, 0x22, 0x33, 0x44 at addresses 0x201..0x204, and grant withheld 2 cycles on byte 1 → wb_data = 0x4433_2211, retire at T+8.
- SH 0xABCD_1234 at 0xFFFF_FFFF → writes 0x34 at 0xFFFF_FFFF, then 0x12 at 0x0000_0000; retire with wb_rd = 0; ex_ready stays low throughout.
- Reset asserted while LW is in XFER after 2 grants → all outputs 0 immediately. After release, a new LH of 0xFF7F data returns 0xFFFF_FF7F.
- Back-to-back: LW to rd = 0, then an ALU op to rd = 3 → first retire has wb_rd = 0; the ALU op is accepted the cycle after and retires with wb_rd = 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, funct3 load/store encodings and
// memory-stage state encoding.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN,
      RETIRE
   } mem_state_t;

   // Index of the final byte of an access, from funct3[1:0].
   function automatic logic [1:0] last_byte(input logic [1:0] size);
      case (size)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word by access size.
module load_extend
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] asm_word,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext_word
);

   logic sgn;
   assign sgn = ~funct3[2];

   always_comb begin
      ext_word = asm_word;
      case (funct3[1:0])
         2'b00:   ext_word = {{24{sgn & asm_word[7]}}, asm_word[7:0]};
         2'b01:   ext_word = {{16{sgn & asm_word[15]}}, asm_word[15:0]};
         default: ext_word = asm_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through and byte-serial loads/stores over an
// 8-bit memory port, feeding the register file write port.
module mem_stage
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_is_load,
   input  logic              ex_is_store,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_addr,
   input  logic [XLEN-1:0]   ex_wdata,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_result,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_grant,
   input  logic [7:0]        mem_rdata,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic [XLEN-1:0]   wb_data
);

   mem_state_t        state;
   logic [XLEN-1:0]   base_q;
   logic [XLEN-1:0]   wdata_q;
   logic [REG_AW-1:0] rd_q;
   logic [2:0]        f3_q;
   logic              store_q;
   logic [1:0]        tx_cnt;
   logic [1:0]        tx_nxt;
   logic [1:0]        rx_cnt;
   logic              rx_pend;
   logic [XLEN-1:0]   asm_q;
   logic [XLEN-1:0]   asm_next;
   logic [XLEN-1:0]   ext_word;

   assign ex_ready = (state == IDLE);
   assign tx_nxt   = tx_cnt + 2'd1;

   // Read data arrives the cycle after its grant; merge it here so DRAIN can
   // retire the word in the same cycle the final byte lands.
   always_comb begin
      asm_next = asm_q;
      if (rx_pend)
         asm_next[{rx_cnt, 3'b000} +: 8] = mem_rdata;
   end

   load_extend u_load_extend (
      .asm_word (asm_next),
      .funct3   (f3_q),
      .ext_word (ext_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         base_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         f3_q      <= '0;
         store_q   <= 1'b0;
         tx_cnt    <= '0;
         rx_cnt    <= '0;
         rx_pend   <= 1'b0;
         asm_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
      end else begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         rx_pend  <= 1'b0;
         if (rx_pend) begin
            asm_q  <= asm_next;
            rx_cnt <= rx_cnt + 2'd1;
         end

         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (ex_is_load || ex_is_store) begin
                     base_q    <= ex_addr;
                     wdata_q   <= ex_wdata;
                     rd_q      <= ex_rd;
                     f3_q      <= ex_funct3;
                     store_q   <= ex_is_store;
                     tx_cnt    <= '0;
                     rx_cnt    <= '0;
                     asm_q     <= '0;
                     mem_req   <= 1'b1;
                     mem_we    <= ex_is_store;
                     mem_addr  <= ex_addr;
                     mem_wdata <= ex_wdata[7:0];
                     state     <= XFER;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_result;
                  end
               end
            end

            XFER: begin
               if (mem_grant) begin
                  rx_pend <= ~store_q;
                  if (tx_cnt == last_byte(f3_q[1:0])) begin
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                     mem_addr  <= '0;
                     mem_wdata <= '0;
                     if (store_q) begin
                        wb_valid <= 1'b1;
                        state    <= RETIRE;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     tx_cnt    <= tx_nxt;
                     mem_addr  <= base_q + 32'(tx_nxt);
                     mem_wdata <= wdata_q[{tx_nxt, 3'b000} +: 8];
                  end
               end
            end

            DRAIN: begin
               wb_valid <= 1'b1;
               wb_rd    <= rd_q;
               wb_data  <= ext_word;
               state    <= RETIRE;
            end

            RETIRE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage with a byte-wide memory model and grant stalls.
module tb_mem_stage;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata, ex_result;
   logic [4:0]  ex_rd;
   logic        mem_req, mem_we, mem_grant;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .ex_result(ex_result),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_grant(mem_grant), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int passed = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act === exp_v) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
   endfunction

   // ---------------- memory model ----------------
   logic [7:0]  mem [logic [31:0]];
   logic [31:0] hold_addr = '0;
   int          hold_left = 0;
   int          req_cycles = 0;
   typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
   wr_t wr_log[$];

   assign mem_grant = mem_req && !(hold_left != 0 && mem_addr == hold_addr);

   always @(posedge clk) begin
      if (mem_req) req_cycles++;
      if (mem_req && !mem_grant && hold_left != 0) hold_left <= hold_left - 1;
      if (mem_req && mem_grant && mem_we) begin
         wr_log.push_back({mem_addr, mem_wdata});
         mem[mem_addr] = mem_wdata;
      end
      if (mem_req && mem_grant && !mem_we)
         mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'hEE;
      else
         mem_rdata <= 8'hA5;
   end

   // ---------------- protocol watchers ----------------
   logic        p_req = 1'b0, p_grant = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0;
   logic [7:0]  p_wd = '0;
   int stab_viol = 0;
   int idle_viol = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (p_req && !p_grant &&
             (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
            stab_viol++;
         if (!wb_valid && (wb_rd != 0 || wb_data != 0)) idle_viol++;
      end
      p_req   = mem_req & rst;
      p_grant = mem_grant;
      p_we    = mem_we;
      p_addr  = mem_addr;
      p_wd    = mem_wdata;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          chk_data;
      int          due;
      string       name;
   } exp_t;
   exp_t sb[$];

   function automatic void push(input logic [4:0] rd, input logic [31:0] data,
                                input bit chk, input int due, input string nm);
      exp_t e;
      e.rd = rd; e.data = data; e.chk_data = chk; e.due = due; e.name = nm;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst && wb_valid) begin
         if (sb.size() == 0) begin
            check("unexpected wb_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, " wb_rd"}, 32'(wb_rd), 32'(e.rd));
            if (e.chk_data) check({e.name, " wb_data"}, wb_data, e.data);
            check({e.name, " retire cycle"}, 32'(cyc + 1), 32'(e.due));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] res, input logic [4:0] rd, output int t);
      int guard;
      guard = 0;
      @(negedge clk);
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
      ex_addr = addr; ex_wdata = wd; ex_result = res; ex_rd = rd;
      while (!ex_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!ex_ready) check("accept timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      t = cyc;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         check("retire timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " mem_req"},   32'(mem_req),   32'd0);
      check({tag, " mem_we"},    32'(mem_we),    32'd0);
      check({tag, " mem_addr"},  mem_addr,       32'd0);
      check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, " wb_valid"},  32'(wb_valid),  32'd0);
      check({tag, " wb_rd"},     32'(wb_rd),     32'd0);
      check({tag, " wb_data"},   wb_data,        32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t, t2, r0;
      rst = 1'b0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_result = '0; ex_rd = '0;
      mem[32'h100] = 8'h80;
      mem[32'h201] = 8'h11; mem[32'h202] = 8'h22;
      mem[32'h203] = 8'h33; mem[32'h204] = 8'h44;
      mem[32'h300] = 8'h7F; mem[32'h301] = 8'hFF;
      mem[32'h400] = 8'h01; mem[32'h401] = 8'h02;
      mem[32'h402] = 8'h03; mem[32'h403] = 8'h04;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      #1 check("ex_ready after reset", 32'(ex_ready), 32'd1);

      // ALU pass-through
      r0 = req_cycles;
      issue(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'h1234_5678, 5'd5, t);
      push(5'd5, 32'h1234_5678, 1'b1, t + 1, "alu");
      drain();
      check("alu mem_req cycles", 32'(req_cycles - r0), 32'd0);

      // LB / LBU of 0x80
      issue(1'b1, 1'b0, F3_B, 32'h100, 32'h0, 32'h0, 5'd7, t);
      push(5'd7, 32'hFFFF_FF80, 1'b1, t + 3, "lb");
      drain();
      issue(1'b1, 1'b0, F3_BU, 32'h100, 32'h0, 32'h0, 5'd8, t);
      push(5'd8, 32'h0000_0080, 1'b1, t + 3, "lbu");
      drain();

      // misaligned LW with a 2-cycle stall on byte 1
      hold_addr = 32'h202;
      hold_left = 2;
      issue(1'b1, 1'b0, F3_W, 32'h201, 32'h0, 32'h0, 5'd9, t);
      push(5'd9, 32'h4433_2211, 1'b1, t + 8, "lw stall");
      drain();

      // SH wrapping the address space
      wr_log.delete();
      issue(1'b0, 1'b1, F3_H, 32'hFFFF_FFFF, 32'hABCD_1234, 32'h0, 5'd12, t);
      push(5'd0, 32'h0, 1'b0, t + 3, "sh");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sh ex_ready busy", 32'(ex_ready), 32'd0);
      end
      drain();
      check("sh write count", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check("sh byte0 addr", wr_log[0].a, 32'hFFFF_FFFF);
         check("sh byte0 data", 32'(wr_log[0].d), 32'h34);
         check("sh byte1 addr", wr_log[1].a, 32'h0000_0000);
         check("sh byte1 data", 32'(wr_log[1].d), 32'h12);
      end

      // reset during LW after two grants
      issue(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 32'h0, 5'd10, t);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check_all_zero("mid-xfer reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check("ex_ready after re-reset", 32'(ex_ready), 32'd1);
      issue(1'b1, 1'b0, F3_H, 32'h300, 32'h0, 32'h0, 5'd11, t);
      push(5'd11, 32'hFFFF_FF7F, 1'b1, t + 4, "lh after reset");
      drain();

      // back-to-back: LW to x0 then ALU to x3
      issue(1'b1, 1'b0, F3_W, 32'h201, 32'h0, 32'h0, 5'd0, t);
      push(5'd0, 32'h0, 1'b0, t + 6, "lw x0");
      issue(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'hCAFE_0003, 5'd3, t2);
      push(5'd3, 32'hCAFE_0003, 1'b1, t2 + 1, "alu after lw");
      check("alu accept after retire", 32'(t2), 32'(t + 7));
      drain();

      check("mem outputs stable while stalled", 32'(stab_viol), 32'd0);
      check("wb zero when idle", 32'(idle_viol), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
